// File: rtl/pattern_autoplayer.sv
// Automated game partner: records symbols shown on pattern_leds, then replays them as timed one-hot button presses.
// Optional feature: define AUTOPLAYER_MISTAKE_EN to add inject_error, which corrupts the last replayed symbol.
module pattern_autoplayer #(
  parameter int MAX_LEN      = 25,
  parameter int PRESS_CYCLES = 4,
  parameter int GAP_CYCLES   = 4,
  parameter int IDLE_TIMEOUT = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [7:0]                   pattern_leds,
  input  logic                         game_over,
`ifdef AUTOPLAYER_MISTAKE_EN
  input  logic                         inject_error,
`endif
  output logic [7:0]                   buttons,
  output logic                         start_button,
  output logic                         busy,
  output logic [$clog2(MAX_LEN+1)-1:0] seq_len,
  output logic                         overflow
);

  localparam int LW     = $clog2(MAX_LEN + 1);
  localparam int DEPTH  = 1 << LW;
  localparam int CMAX_A = (PRESS_CYCLES > GAP_CYCLES) ? PRESS_CYCLES : GAP_CYCLES;
  localparam int CMAX   = (CMAX_A > IDLE_TIMEOUT) ? CMAX_A : IDLE_TIMEOUT;
  localparam int CW     = $clog2(CMAX + 1);

  localparam logic [CW-1:0] PRESS_LAST = CW'(PRESS_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] DARK_LAST  = CW'(IDLE_TIMEOUT - 1);
  localparam logic [CW-1:0] DARK_MAX   = CW'(IDLE_TIMEOUT);
  localparam logic [LW-1:0] LEN_MAX    = LW'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WATCH = 3'd2,
    S_PRESS = 3'd3,
    S_GAP   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [LW-1:0] seq_len_q, seq_len_d;
  logic [LW-1:0] rd_ptr_q, rd_ptr_d;
  logic          overflow_q, overflow_d;
  logic          err_q, err_d;
  logic [7:0]    led_prev_q;
  logic [7:0]    buttons_q, buttons_d;
  logic          start_q, start_d;
  logic          busy_q, busy_d;
  logic          cap_we_s;
  logic          inject_s;
  logic [2:0]    sym_s;
  logic [2:0]    buf_q [DEPTH];

  // Lowest set bit wins, matching the chip's button priority encoder.
  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    lowest_set = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) lowest_set = 3'(i);
    end
  endfunction

`ifdef AUTOPLAYER_MISTAKE_EN
  assign inject_s = inject_error;
`else
  assign inject_s = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      seq_len_q  <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      err_q      <= 1'b0;
      led_prev_q <= 8'd0;
      buttons_q  <= 8'd0;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      seq_len_q  <= seq_len_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
      err_q      <= err_d;
      led_prev_q <= pattern_leds;
      buttons_q  <= buttons_d;
      start_q    <= start_d;
      busy_q     <= busy_d;
    end
  end

  always_ff @(posedge clock) begin
    if (cap_we_s) buf_q[seq_len_q] <= lowest_set(pattern_leds);
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    seq_len_d  = seq_len_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    err_d      = err_q;
    cap_we_s   = 1'b0;
    if (!enable) begin
      state_d   = S_IDLE;
      cnt_d     = '0;
      seq_len_d = '0;
      rd_ptr_d  = '0;
    end else if (game_over && (state_q == S_START || state_q == S_WATCH ||
                               state_q == S_PRESS || state_q == S_GAP)) begin
      state_d = S_DONE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!game_over) begin
            state_d    = S_START;
            cnt_d      = '0;
            overflow_d = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_START: begin
          if (cnt_q == PRESS_LAST) begin
            state_d   = S_WATCH;
            cnt_d     = '0;
            seq_len_d = '0;
            rd_ptr_d  = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        // cnt_q doubles as the dark-cycle counter while watching.
        S_WATCH: begin
          if (pattern_leds != 8'd0) begin
            cnt_d = '0;
            if (led_prev_q == 8'd0) begin
              if (seq_len_q == LEN_MAX) begin
                overflow_d = 1'b1;
              end else begin
                cap_we_s  = 1'b1;
                seq_len_d = seq_len_q + LW'(1);
              end
            end else begin
              cap_we_s = 1'b0;
            end
          end else if (cnt_q >= DARK_LAST && seq_len_q != '0) begin
            state_d  = S_PRESS;
            cnt_d    = '0;
            rd_ptr_d = '0;
          end else if (cnt_q != DARK_MAX) begin
            cnt_d = cnt_q + CW'(1);
          end else begin
            cnt_d = cnt_q;
          end
        end
        S_PRESS: begin
          if (cnt_q == PRESS_LAST) begin
            state_d = S_GAP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_GAP: begin
          if (cnt_q == GAP_LAST) begin
            cnt_d = '0;
            if (rd_ptr_q + LW'(1) == seq_len_q) begin
              state_d   = S_WATCH;
              seq_len_d = '0;
              rd_ptr_d  = '0;
            end else begin
              state_d  = S_PRESS;
              rd_ptr_d = rd_ptr_q + LW'(1);
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_DONE: begin
          state_d = S_DONE;
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
    // Mistake decision is latched once, when a press begins.
    if (state_d == S_PRESS && state_q != S_PRESS) begin
      err_d = inject_s && (rd_ptr_d == seq_len_q - LW'(1));
    end else begin
      err_d = (state_d == S_PRESS) ? err_q : 1'b0;
    end
  end

  always_comb begin
    buttons_d = 8'd0;
    start_d   = 1'b0;
    busy_d    = 1'b0;
    sym_s     = buf_q[rd_ptr_d] + {2'b00, err_d};
    case (state_d)
      S_START: begin
        start_d = 1'b1;
        busy_d  = 1'b1;
      end
      S_WATCH, S_GAP: begin
        busy_d = 1'b1;
      end
      S_PRESS: begin
        busy_d    = 1'b1;
        buttons_d = 8'd1 << sym_s;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  assign buttons      = buttons_q;
  assign start_button = start_q;
  assign busy         = busy_q;
  assign seq_len      = seq_len_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_pattern_autoplayer.sv
// Bench for pattern_autoplayer: a vector table for reset/start/single-symbol replay, plus
// hand sequences for ordering, buffer overflow (second instance with MAX_LEN=2), game_over and mistakes.
module tb_pattern_autoplayer;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic       game_over;
  logic [7:0] leds;
`ifdef AUTOPLAYER_MISTAKE_EN
  logic       inject_error;
`endif

  logic [7:0] btn_a, btn_b;
  logic       start_a, start_b, busy_a, busy_b, ovf_a, ovf_b;
  logic [4:0] len_a;
  logic [1:0] len_b;

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0] syms    [4];
  logic [7:0] exp_btn [4];
  int         nsyms;

  always #5 clock = ~clock;

  pattern_autoplayer dut (
    .clock(clock), .reset(reset), .enable(enable), .pattern_leds(leds), .game_over(game_over),
`ifdef AUTOPLAYER_MISTAKE_EN
    .inject_error(inject_error),
`endif
    .buttons(btn_a), .start_button(start_a), .busy(busy_a), .seq_len(len_a), .overflow(ovf_a)
  );

  pattern_autoplayer #(.MAX_LEN(2)) dut2 (
    .clock(clock), .reset(reset), .enable(enable), .pattern_leds(leds), .game_over(game_over),
`ifdef AUTOPLAYER_MISTAKE_EN
    .inject_error(inject_error),
`endif
    .buttons(btn_b), .start_button(start_b), .busy(busy_b), .seq_len(len_b), .overflow(ovf_b)
  );

  typedef struct {
    logic       rst;
    logic       en;
    logic       go;
    logic [7:0] leds;
    int         n;
    logic [7:0] btn;
    logic       start;
    logic       busy;
    int         len;
  } vec_t;

  vec_t vecs [14];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic int cur_btn(input int sel);
    return (sel != 0) ? int'(btn_b) : int'(btn_a);
  endfunction

  function automatic int cur_len(input int sel);
    return (sel != 0) ? int'(len_b) : int'(len_a);
  endfunction

  function automatic int cur_busy(input int sel);
    return (sel != 0) ? int'(busy_b) : int'(busy_a);
  endfunction

  // Restart a round and show syms[0..nsyms-1], each 6 cycles lit then 3 dark.
  task automatic capture();
    enable = 1'b0; game_over = 1'b0; leds = 8'h00;
    step(); step();
    check("idle_busy", int'(busy_a), 0);
    check("idle_len", int'(len_a), 0);
    enable = 1'b1;
    repeat (4) step();
    check("start_hi", int'(start_a), 1);
    step();
    check("start_lo", int'(start_a), 0);
    check("watch_busy", int'(busy_a), 1);
    check("ovf_cleared", int'(ovf_b), 0);
    for (int i = 0; i < nsyms; i++) begin
      leds = syms[i];
      step();
      check("cap_len_a", int'(len_a), i + 1);
      check("cap_len_b", int'(len_b), (i + 1 > 2) ? 2 : i + 1);
      check("cap_ovf_b", int'(ovf_b), (i >= 2) ? 1 : 0);
      repeat (5) step();
      leds = 8'h00;
      repeat (3) step();
    end
  endtask

  // Expect exp_btn[0..cnt-1] replayed with 4-cycle presses and 4-cycle gaps, then WATCH.
  task automatic replay(input int sel, input int cnt);
    int k, hi, lo;
    for (int i = 0; i < cnt; i++) begin
      k = 0;
      while (cur_btn(sel) == 0 && k < 40) begin step(); k++; end
      check("press_val", cur_btn(sel), int'(exp_btn[i]));
      hi = 0;
      while (cur_btn(sel) != 0 && cur_btn(sel) == int'(exp_btn[i]) && hi < 20) begin step(); hi++; end
      check("press_len", hi, 4);
      lo = 0;
      while (cur_btn(sel) == 0 && lo < 10) begin step(); lo++; end
      check("gap_len", lo, (i == cnt - 1) ? 10 : 4);
    end
    check("rewatch_len", cur_len(sel), 0);
    check("rewatch_busy", cur_busy(sel), 1);
  endtask

  initial begin
    int k;
    reset = 1'b1; enable = 1'b0; game_over = 1'b0; leds = 8'h00;
`ifdef AUTOPLAYER_MISTAKE_EN
    inject_error = 1'b0;
`endif
    //           rst   en    go    leds   n   btn    start busy  len
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 2,  8'h00, 1'b0, 1'b0, 0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1,  8'h00, 1'b0, 1'b0, 0};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 8'h00, 2,  8'h00, 1'b0, 1'b0, 0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 8'h00, 4,  8'h00, 1'b1, 1'b1, 0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1,  8'h00, 1'b0, 1'b1, 0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 8'h04, 1,  8'h00, 1'b0, 1'b1, 1};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 8'h04, 9,  8'h00, 1'b0, 1'b1, 1};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 8'h00, 15, 8'h00, 1'b0, 1'b1, 1};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1,  8'h04, 1'b0, 1'b1, 1};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 8'h00, 3,  8'h04, 1'b0, 1'b1, 1};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 8'h00, 1,  8'h00, 1'b0, 1'b1, 1};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 8'h00, 3,  8'h00, 1'b0, 1'b1, 1};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 8'h00, 1,  8'h00, 1'b0, 1'b1, 0};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 8'h00, 20, 8'h00, 1'b0, 1'b1, 0};

    for (int v = 0; v < 14; v++) begin
      reset = vecs[v].rst; enable = vecs[v].en; game_over = vecs[v].go; leds = vecs[v].leds;
      repeat (vecs[v].n) step();
      check($sformatf("vec%0d_btn", v), int'(btn_a), int'(vecs[v].btn));
      check($sformatf("vec%0d_start", v), int'(start_a), int'(vecs[v].start));
      check($sformatf("vec%0d_busy", v), int'(busy_a), int'(vecs[v].busy));
      check($sformatf("vec%0d_len", v), int'(len_a), vecs[v].len);
    end

    // Three symbols replayed in order.
    syms[0] = 8'h01; syms[1] = 8'h80; syms[2] = 8'h10; nsyms = 3;
    exp_btn[0] = 8'h01; exp_btn[1] = 8'h80; exp_btn[2] = 8'h10;
    capture();
    replay(0, 3);

    // Buffer of two: third symbol dropped, overflow sticky into DONE.
    capture();
    check("ovf_len_b", int'(len_b), 2);
    replay(1, 2);
    check("ovf_hold_watch", int'(ovf_b), 1);
    game_over = 1'b1;
    step();
    game_over = 1'b0;
    check("ovf_done_busy", int'(busy_b), 0);
    check("ovf_done_hold", int'(ovf_b), 1);

    // game_over in the middle of the second press.
    capture();
    k = 0;
    while (btn_a != 8'h80 && k < 60) begin step(); k++; end
    check("second_press", int'(btn_a), 32'h80);
    step();
    game_over = 1'b1;
    step();
    check("go_btn", int'(btn_a), 0);
    check("go_busy", int'(busy_a), 0);
    check("go_len_held", int'(len_a), 3);
    game_over = 1'b0;
    step();
    check("done_stays", int'(busy_a), 0);
    check("done_len", int'(len_a), 3);
    enable = 1'b0;
    step();
    check("idle_len_clr", int'(len_a), 0);
    check("idle_btn", int'(btn_a), 0);
    check("idle_busy2", int'(busy_a), 0);

    // Multi-bit LED pattern replays its lowest set bit.
    syms[0] = 8'h06; nsyms = 1; exp_btn[0] = 8'h02;
    capture();
    replay(0, 1);

`ifdef AUTOPLAYER_MISTAKE_EN
    inject_error = 1'b1;
    exp_btn[0] = 8'h04;
    capture();
    replay(0, 1);
    syms[0] = 8'h06; syms[1] = 8'h01; nsyms = 2;
    exp_btn[0] = 8'h02; exp_btn[1] = 8'h02;
    capture();
    replay(0, 2);
    inject_error = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
